// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core (port 0) and the
// host/loader (port 1). Round-robin single accesses, host bursts that lock
// the memory for several beats, registered read return with valid strobes.
module dmem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8,
   parameter int BW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_stall,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   input  logic          h_req,
   input  logic          h_we,
   input  logic [AW-1:0] h_addr,
   input  logic [DW-1:0] h_wdata,
   input  logic [BW-1:0] h_blen,
   output logic          h_gnt,
   output logic          h_rvalid,
   output logic [DW-1:0] h_rdata,
   output logic          h_busy,
   output logic          mem_wr_en,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic {ARB, BURST} state_t;

   state_t        state, state_nxt;
   logic          ptr, ptr_nxt;          // 0: core favoured, 1: host favoured
   logic [AW-1:0] baddr, baddr_nxt;      // next burst beat address
   logic [BW-1:0] bcnt, bcnt_nxt;        // beats still to issue in the burst
   logic          bwe, bwe_nxt;          // direction latched at burst start
   logic [AW-1:0] last_addr;             // keeps mem_addr stable when idle

   logic          cg, hg;
   logic          we_sel;
   logic [AW-1:0] addr_sel;
   logic [DW-1:0] wdata_sel;

   // Grant selection, memory mux and next-state logic; nothing is granted in reset.
   always_comb begin
      cg        = 1'b0;
      hg        = 1'b0;
      we_sel    = 1'b0;
      addr_sel  = last_addr;
      wdata_sel = '0;
      state_nxt = state;
      ptr_nxt   = ptr;
      baddr_nxt = baddr;
      bcnt_nxt  = bcnt;
      bwe_nxt   = bwe;
      if (!reset) begin
         case (state)
            ARB: begin
               if (c_req && (!h_req || !ptr)) begin
                  cg        = 1'b1;
                  addr_sel  = c_addr;
                  we_sel    = c_we;
                  wdata_sel = c_wdata;
                  ptr_nxt   = 1'b1;
               end else if (h_req) begin
                  hg        = 1'b1;
                  addr_sel  = h_addr;
                  we_sel    = h_we;
                  wdata_sel = h_wdata;
                  ptr_nxt   = 1'b0;
                  if (h_blen > BW'(1)) begin
                     // first beat goes out now; the rest come from the latched context
                     baddr_nxt = h_addr + AW'(1);
                     bcnt_nxt  = h_blen - BW'(1);
                     bwe_nxt   = h_we;
                     state_nxt = BURST;
                  end
               end
            end
            BURST: begin
               if (h_req) begin
                  hg        = 1'b1;
                  addr_sel  = baddr;
                  we_sel    = bwe;
                  wdata_sel = h_wdata;
                  baddr_nxt = baddr + AW'(1);
                  bcnt_nxt  = bcnt - BW'(1);
                  if (bcnt == BW'(1)) begin
                     state_nxt = ARB;
                     ptr_nxt   = 1'b0;
                  end
               end
            end
            default: state_nxt = ARB;
         endcase
      end
   end

   assign c_gnt     = cg;
   assign h_gnt     = hg;
   assign c_stall   = c_req & ~cg & ~reset;
   assign h_busy    = (state == BURST);
   assign mem_wr_en = (cg | hg) & we_sel;
   assign mem_addr  = reset ? '0 : addr_sel;
   assign mem_wdata = wdata_sel;

   // Control state, burst context and registered read return.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ARB;
         ptr       <= 1'b0;
         baddr     <= '0;
         bcnt      <= '0;
         bwe       <= 1'b0;
         last_addr <= '0;
         c_rvalid  <= 1'b0;
         h_rvalid  <= 1'b0;
         c_rdata   <= '0;
         h_rdata   <= '0;
      end else begin
         state     <= state_nxt;
         ptr       <= ptr_nxt;
         baddr     <= baddr_nxt;
         bcnt      <= bcnt_nxt;
         bwe       <= bwe_nxt;
         last_addr <= addr_sel;
         c_rvalid  <= cg & ~we_sel;
         h_rvalid  <= hg & ~we_sel;
         if (cg && !we_sel) c_rdata <= mem_rdata;
         if (hg && !we_sel) h_rdata <= mem_rdata;
      end
   end

endmodule
